inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Decoupling FIFO between the fetch stage and the decode stage. It buffers fetched instructions with their PC/NPC so fetch keeps running while rename/dispatch stalls. It presents the oldest entry to the decoder, which takes `if_id_IR_i` / `if_id_valid_inst_i` from this block's outputs. It is flushed on branch mispredict or exception recovery, and stops accepting instructions after a halt until it is flushed.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two and at least 2.
- `PTR_W`, default `$clog2(DEPTH)`: width of the read and write pointers.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the occupancy count.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `if_valid_i`  in  1  fetch offers an instruction this cycle.
- `if_IR_i`  in  32  fetched instruction word.
- `if_PC_i`  in  64  PC of the fetched instruction.
- `if_NPC_i`  in  64  predicted next PC.
- `dispatch_en_i`  in  1  decode/dispatch consumes the head entry this cycle.
- `flush_i`  in  1  squash all entries (mispredict or exception).
- `if_id_IR_o`  out  32  head instruction; `NOOP_INST` when the queue is empty.
- `if_id_PC_o`  out  64  head PC; 0 when empty.
- `if_id_NPC_o`  out  64  head NPC; 0 when empty.
- `if_id_valid_inst_o`  out  1  head entry is valid (queue not empty).
- `fq_full_o`  out  1  count == DEPTH; fetch must stall.
- `fq_empty_o`  out  1  count == 0.
- `fq_count_o`  out  CNT_W  current occupancy.
- `fq_halted_o`  out  1  a HALT has been enqueued; pushes are blocked.

## Operation
- Storage: circular array of DEPTH entries {IR, PC, NPC}.
  - `head` (read pointer, PTR_W bits), `tail` (write pointer, PTR_W bits), `count` (CNT_W bits).
  - Pointers wrap modulo DEPTH by natural overflow.
- Push accepted: `if_valid_i & ~fq_full_o & ~fq_halted_o & ~flush_i`.
  - Writes the entry at `tail`; `tail` increments.
- Pop: `dispatch_en_i & ~fq_empty_o & ~flush_i`; `head` increments.
  - `dispatch_en_i` while empty is ignored: no pointer change and no error.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
  - Legal at any non-empty occupancy, including full.
  - At full, push is refused because `fq_full_o` is evaluated on registered count. Only the pop occurs.
- Push into an empty queue with a simultaneous `dispatch_en_i`: only the push occurs. The new entry is not bypassed.
- Halt detection: an accepted push with `if_IR_i[31:26] == PAL_INST` and `if_IR_i[25:0] == PAL_HALT` sets the `halted` flag on that edge.
  - The halt instruction itself is enqueued.
  - While `halted` is set, all later pushes are refused.
- Flush (highest priority):
  - `head`, `tail` and `count` go to 0 and `halted` clears.
  - Any push or pop in the same cycle is discarded.
- Outputs are combinational from registered state only; there is no combinational path from any input to any output.
  - `if_id_*_o` = array[head] when count != 0, otherwise NOOP/0/0.
  - `fq_full_o`, `fq_empty_o` and `fq_halted_o` decode registers only.
- Reset (asynchronous): `head`, `tail`, `count` and `halted` go to 0.
  - Outputs immediately read: `if_id_IR_o` = `NOOP_INST`, PC/NPC = 0, `if_id_valid_inst_o` = 0, `fq_full_o` = 0, `fq_empty_o` = 1, `fq_count_o` = 0, `fq_halted_o` = 0.
  - Array contents need not be cleared.
- Reset asserted in the middle of a push or pop wins: the in-flight operation is lost.

## Timing
- Enqueue-to-visible latency is 1 cycle. An entry pushed at edge N appears on `if_id_*_o` after edge N, provided the queue was empty.
- Pop takes effect at the edge. The next-oldest entry is presented in the following cycle.
- `fq_full_o` reflects the pre-edge count. Fetch samples it in the same cycle it drives `if_valid_i`.
- Flush asserted at edge N: outputs show empty after edge N. A push in cycle N+1 is accepted normally.
- Throughput is 1 push and 1 pop per cycle, sustained.

## Test plan
- Reset, then push IR = 0x40220401 (addq r1,r2,r1) with PC = 0x0, NPC = 0x4 and `dispatch_en_i` = 0 -> next cycle `if_id_valid_inst_o` = 1, IR = 0x40220401, PC = 0, NPC = 4, `fq_count_o` = 1.
- Push 8 instructions (PC 0x0..0x1C) without popping -> `fq_full_o` = 1 and a 9th push is refused (count stays 8). Then pop 8 -> outputs show PC 0x0..0x1C in order, then `fq_empty_o` = 1 and IR = `NOOP_INST`.
- Full queue with push and pop in the same cycle -> only the pop occurs and count = 7. Then 20 cycles of simultaneous push and pop from count 4 -> count stays 4, with correct FIFO order across pointer wrap.
- Push 3 entries, then assert `flush_i` together with a push and `dispatch_en_i` -> next cycle count = 0, valid = 0, and the flushed push is absent.
- Push IR = 0x00000555 (HALT) followed by 2 more instructions -> `fq_halted_o` = 1, count = 1 and later pushes are refused. Pop the halt -> the queue empties and stays halted. `flush_i` -> `fq_halted_o` = 0.
- Assert `rst` asynchronously mid-cycle with 5 entries queued -> outputs go to reset values before the next clock edge.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular FIFO decoupling fetch from decode.
// Holds {IR, PC, NPC} per entry, presents the oldest entry to decode,
// squashes everything on flush and blocks pushes once a HALT is enqueued.
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid_i,
  input  logic [31:0]      if_IR_i,
  input  logic [63:0]      if_PC_i,
  input  logic [63:0]      if_NPC_i,
  input  logic             dispatch_en_i,
  input  logic             flush_i,
  output logic [31:0]      if_id_IR_o,
  output logic [63:0]      if_id_PC_o,
  output logic [63:0]      if_id_NPC_o,
  output logic             if_id_valid_inst_o,
  output logic             fq_full_o,
  output logic             fq_empty_o,
  output logic [CNT_W-1:0] fq_count_o,
  output logic             fq_halted_o
);

  // Alpha-style encodings: canonical no-op and the PAL halt call.
  localparam logic [31:0] NOOP_INST = 32'h47ff_041f;
  localparam logic [5:0]  PAL_INST  = 6'h00;
  localparam logic [25:0] PAL_HALT  = 26'h555;

  typedef struct packed {
    logic [31:0] ir;
    logic [63:0] pc;
    logic [63:0] npc;
  } fq_entry_t;

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             halted;

  logic push, pop, is_halt;
  fq_entry_t head_ent;

  // Full/empty decode registered count only, so fetch sees the pre-edge state.
  assign fq_full_o   = (count == CNT_W'(DEPTH));
  assign fq_empty_o  = (count == '0);
  assign fq_count_o  = count;
  assign fq_halted_o = halted;

  // Flush squashes any same-cycle traffic; pop never bypasses a push into empty.
  assign push    = if_valid_i & ~fq_full_o & ~halted & ~flush_i;
  assign pop     = dispatch_en_i & ~fq_empty_o & ~flush_i;
  assign is_halt = (if_IR_i[31:26] == PAL_INST) && (if_IR_i[25:0] == PAL_HALT);

  // Head presentation: NOOP/0/0 whenever the queue is empty.
  always_comb begin
    head_ent           = mem[head];
    if_id_valid_inst_o = ~fq_empty_o;
    if_id_IR_o         = NOOP_INST;
    if_id_PC_o         = '0;
    if_id_NPC_o        = '0;
    if (~fq_empty_o) begin
      if_id_IR_o  = head_ent.ir;
      if_id_PC_o  = head_ent.pc;
      if_id_NPC_o = head_ent.npc;
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{ir: if_IR_i, pc: if_PC_i, npc: if_NPC_i};
  end

  // Pointer, occupancy and halt state; flush has top priority after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else if (flush_i) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (push && is_halt) halted <= 1'b1;
    end
  end

endmodule
